seg_led_shift_ctrl: RTL and testbench
=====================================

Name: seg_led_shift_ctrl

Overview:
- Serial output controller for the board's two shift-register chains: the 8-digit seven-segment chain (seg_*) and the 16-LED chain (led_*).
- Accepts parallel write requests from DeviceIO, buffers one pending word per chain, and shares a single bit-serial shift engine between both chains.
- The engine uses round-robin arbitration, drives clock, data, latch-enable and clear pins, and reports completion.
- Sits inside DeviceIO on clk_main, between the IO register file and the board pins.

Parameters:
CLK_DIV, 4, clk cycles per half-period of the serial clock (≥1)
SEG_BITS, 64, bits per seven-segment transfer (8 digits × 8 raw segment bits, active-low segments as supplied)
LED_BITS, 16, bits per LED transfer

Ports:
clk  in  1  system clock (clk_main)
rst  in  1  synchronous, active-high reset
seg_wr  in  1  one-cycle strobe: capture seg_wdata as pending seven-segment word
seg_wdata  in  SEG_BITS  seven-segment pattern, bit SEG_BITS-1 shifted first
led_wr  in  1  one-cycle strobe: capture led_wdata as pending LED word
led_wdata  in  LED_BITS  LED pattern, bit LED_BITS-1 shifted first
seg_busy  out  1  seg word pending or being shifted
led_busy  out  1  led word pending or being shifted
seg_done  out  1  one-cycle pulse: seg transfer latched
led_done  out  1  one-cycle pulse: led transfer latched
seg_clk, seg_do, seg_pen, seg_clr_n  out  1 each  seg chain pins
led_clk, led_do, led_pen, led_clr_n  out  1 each  led chain pins

Behaviour:
- Reset (synchronous, active-high):
  - All pin clocks and data outputs are 0; pen outputs are 1; clr_n outputs are 0.
  - busy and done outputs are 0; pending flags are cleared.
  - The round-robin pointer favours seg.
  - clr_n rises on the first clock edge after rst deasserts.
- Reset during a transfer aborts it immediately with the same values above. The partial word is discarded and no done pulse is issued.
- Pending buffers (one per chain):
  - A wr strobe sets the chain's pending flag and stores the data.
  - A second strobe before the engine takes the word overwrites it (latest wins). There is no error.
  - A strobe during that chain's own active shift goes to pending and is shifted after the current transfer. The active shift is never disturbed.
- Arbitration happens in IDLE only:
  - If exactly one chain is pending, it is granted.
  - If both are pending, the chain not served last is granted. The pointer updates on grant.
- FSM states are IDLE, LOAD, LOW, HIGH, LATCH; bitcnt and divcnt are counters.
  - IDLE:
    - Pins idle with clk=0, do=0, pen=1.
    - If any chain is pending, grant and go to LOAD.
  - LOAD (1 cycle):
    - Copy the pending word into the shift register and clear that chain's pending flag.
    - bitcnt=N-1 (N = SEG_BITS or LED_BITS). pen of the granted chain goes to 0.
    - do takes the word MSB. divcnt=0. Go to LOW.
  - LOW: the granted chain's clk is 0 for CLK_DIV cycles, then clk goes to 1 and the FSM goes to HIGH.
  - HIGH: clk is 1 for CLK_DIV cycles; the chain samples do on the rising edge. At the end of the half-period:
    - If bitcnt==0: clk goes to 0, go to LATCH.
    - Otherwise: clk goes to 0, shift left, do takes the next bit, bitcnt decrements, go to LOW.
  - LATCH:
    - clk=0 for CLK_DIV cycles; then pen goes to 1 and do goes to 0.
    - The chain's done pulses in the same cycle pen rises; go to IDLE.
- Pin isolation: the non-granted chain's pins hold their idle values throughout.
- Latency:
  - Strobe in cycle t with the engine idle and no other pending word: pen rises and done pulses at cycle t + 2 + 2·CLK_DIV·N + CLK_DIV.
  - The next grant is evaluated in the cycle after done; IDLE lasts 1 cycle between back-to-back transfers.
- busy = pending | (engine active on that chain). It deasserts in the cycle after done unless a new word is pending.
- Simultaneous seg_wr and led_wr: both are captured; the order follows the round-robin pointer.
- Width rules: bitcnt width is clog2(max(SEG_BITS, LED_BITS)); divcnt width is clog2(CLK_DIV). The shift register is SEG_BITS wide and LED words are left-aligned into it.

Decomposition:
- The shared package holds:
  - state enum (IDLE, LOAD, LOW, HIGH, LATCH)
  - channel ids (CH_SEG = 0, CH_LED = 1)
  - default SEG_BITS, LED_BITS and CLK_DIV constants
- One natural sub-module, serial_shift_engine: the FSM, counters and shift register for a single granted word, with start/done handshake.
- The top level keeps the pending buffers, the arbiter and the pin muxing.

Test Plan:
- Reset release:
  - Stimulus: rst high 3 cycles, then low.
  - Response: clr_n=0 during reset and rises 1 cycle after; pen=1, clk=0, do=0, busy=0.
- Single LED transfer:
  - Stimulus: CLK_DIV=2; led_wr with 16'hA5C3 at cycle 10.
  - Response: led_pen falls at cycle 12; 16 rising led_clk edges sample 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1; led_done at cycle 10+2+64+2=78; seg pins static.
- Simultaneous requests:
  - Stimulus: seg_wr and led_wr in the same cycle, from reset.
  - Response: seg shifts first (64 bits), led follows after 1 IDLE cycle; seg_done precedes led_done; both busy flags drop after their own done.
- Overwrite while pending:
  - Stimulus: seg active; led_wr 16'h0001, then led_wr 16'hFFFF before the grant.
  - Response: exactly one led transfer, data 16'hFFFF, one led_done.
- Re-write during own shift:
  - Stimulus: led_wr 16'h1234; mid-shift led_wr 16'h5678.
  - Response: the first transfer completes unchanged as 16'h1234, then 16'h5678 shifts; two led_done pulses; led_busy high continuously until the second done.
- Reset mid-transfer:
  - Stimulus: assert rst at the 5th led_clk rising edge.
  - Response: next cycle led_clk=0, led_pen=1, led_clr_n=0, no led_done; after release, the engine is IDLE with nothing pending.

Source files
------------

// File: rtl/seg_led_shift_ctrl_pkg.sv
// seg_led_shift_ctrl_pkg: shared state, channel ids and default sizes for the seg/led serial controller
package seg_led_shift_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, LOW, HIGH, LATCH} state_t;
  localparam logic CH_SEG = 1'b0;
  localparam logic CH_LED = 1'b1;
  localparam int DEF_SEG_BITS = 64;
  localparam int DEF_LED_BITS = 16;
  localparam int DEF_CLK_DIV = 4;
endpackage

// File: rtl/seg_led_shift_ctrl_serial_shift_engine.sv
// serial_shift_engine: shifts one granted word MSB-first with divided clock, then latches
module serial_shift_engine
  import seg_led_shift_ctrl_pkg::*;
#(
  parameter int W       = DEF_SEG_BITS,
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int BW      = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  word,
  input  logic [BW-1:0] last,
  output logic          busy,
  output logic          load,
  output logic          sclk,
  output logic          sdo,
  output logic          pen,
  output logic          done
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  state_t state;
  logic [DW-1:0] divcnt;
  logic [BW-1:0] bitcnt;
  logic [W-1:0] sr;
  logic div_end;
  assign div_end = divcnt == DIV_LAST;
  assign busy = state != IDLE;
  assign load = state == LOAD;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      divcnt <= '0;
      bitcnt <= '0;
      sr     <= '0;
      sclk   <= 1'b0;
      sdo    <= 1'b0;
      pen    <= 1'b1;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) state <= LOAD;
        LOAD: begin
          sr     <= word;
          bitcnt <= last;
          pen    <= 1'b0;
          sdo    <= word[W-1];
          divcnt <= '0;
          state  <= LOW;
        end
        LOW: begin
          divcnt <= div_end ? '0 : divcnt + 1'b1;
          if (div_end) begin
            sclk  <= 1'b1;
            state <= HIGH;
          end
        end
        HIGH: begin
          divcnt <= div_end ? '0 : divcnt + 1'b1;
          if (div_end) begin
            sclk <= 1'b0;
            if (bitcnt == '0) state <= LATCH;
            else begin
              sr     <= sr << 1;
              sdo    <= sr[W-2];
              bitcnt <= bitcnt - 1'b1;
              state  <= LOW;
            end
          end
        end
        LATCH: begin
          divcnt <= div_end ? '0 : divcnt + 1'b1;
          if (div_end) begin
            pen   <= 1'b1;
            sdo   <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/seg_led_shift_ctrl.sv
// seg_led_shift_ctrl: pending buffers and round-robin arbiter sharing one shift engine across seg/led chains
module seg_led_shift_ctrl
  import seg_led_shift_ctrl_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int SEG_BITS = DEF_SEG_BITS,
  parameter int LED_BITS = DEF_LED_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                seg_wr,
  input  logic [SEG_BITS-1:0] seg_wdata,
  input  logic                led_wr,
  input  logic [LED_BITS-1:0] led_wdata,
  output logic                seg_busy,
  output logic                led_busy,
  output logic                seg_done,
  output logic                led_done,
  output logic                seg_clk,
  output logic                seg_do,
  output logic                seg_pen,
  output logic                seg_clr_n,
  output logic                led_clk,
  output logic                led_do,
  output logic                led_pen,
  output logic                led_clr_n
);
  localparam int BW = $clog2(SEG_BITS > LED_BITS ? SEG_BITS : LED_BITS);
  logic seg_pend, led_pend, gnt, clr_n, start, nxt, seg_sel, act;
  logic eng_busy, eng_load, eng_clk, eng_do, eng_pen, eng_done;
  logic [SEG_BITS-1:0] seg_buf, word;
  logic [LED_BITS-1:0] led_buf;
  logic [BW-1:0] last;
  // gnt doubles as the last-served pointer; reset to led so seg wins the first tie
  assign start = !eng_busy && (seg_pend || led_pend);
  assign nxt = seg_pend && led_pend ? ~gnt : (seg_pend ? CH_SEG : CH_LED);
  assign seg_sel = gnt == CH_SEG;
  assign act = eng_busy || eng_done;
  assign word = seg_sel ? seg_buf : SEG_BITS'(led_buf) << (SEG_BITS - LED_BITS);
  assign last = seg_sel ? BW'(SEG_BITS - 1) : BW'(LED_BITS - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_pend <= 1'b0;
      led_pend <= 1'b0;
      gnt      <= CH_LED;
      clr_n    <= 1'b0;
      seg_buf  <= '0;
      led_buf  <= '0;
    end else begin
      clr_n    <= 1'b1;
      if (start) gnt <= nxt;
      seg_pend <= seg_wr || (seg_pend && !(eng_load && seg_sel));
      led_pend <= led_wr || (led_pend && !(eng_load && !seg_sel));
      if (seg_wr) seg_buf <= seg_wdata;
      if (led_wr) led_buf <= led_wdata;
    end
  end
  serial_shift_engine #(.W(SEG_BITS), .CLK_DIV(CLK_DIV), .BW(BW)) u_eng (
    .clk(clk), .rst(rst), .start(start), .word(word), .last(last),
    .busy(eng_busy), .load(eng_load), .sclk(eng_clk), .sdo(eng_do),
    .pen(eng_pen), .done(eng_done)
  );
  assign seg_busy  = seg_pend || (seg_sel && act);
  assign led_busy  = led_pend || (!seg_sel && act);
  assign seg_done  = seg_sel && eng_done;
  assign led_done  = !seg_sel && eng_done;
  assign seg_clk   = seg_sel && eng_clk;
  assign seg_do    = seg_sel && eng_do;
  assign seg_pen   = seg_sel ? eng_pen : 1'b1;
  assign led_clk   = !seg_sel && eng_clk;
  assign led_do    = !seg_sel && eng_do;
  assign led_pen   = seg_sel ? 1'b1 : eng_pen;
  assign seg_clr_n = clr_n;
  assign led_clr_n = clr_n;
endmodule

// File: tb/tb_seg_led_shift_ctrl.sv
// tb_seg_led_shift_ctrl: scoreboard bench; words queued at write, compared when the chain latches
module tb_seg_led_shift_ctrl;
  localparam int CD = 2;
  localparam int LED_LAT = 2 + 2 * CD * 16 + CD;
  localparam int SEG_LAT = 2 + 2 * CD * 64 + CD;
  logic clk = 0, rst = 1, seg_wr = 0, led_wr = 0;
  logic [63:0] seg_wdata = '0;
  logic [15:0] led_wdata = '0;
  logic seg_busy, led_busy, seg_done, led_done;
  logic seg_clk, seg_do, seg_pen, seg_clr_n, led_clk, led_do, led_pen, led_clr_n;
  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [63:0] seg_q[$];
  logic [15:0] led_q[$];
  logic [63:0] seg_sh = '0;
  logic [15:0] led_sh = '0;
  bit lc_q = 0, sc_q = 0, lp_q = 1, sp_q = 1;
  int led_n = 0, seg_n = 0, led_fall = 0, seg_fall = 0;
  int led_done_cyc = 0, seg_done_cyc = 0, led_dones = 0, seg_dones = 0, iso_bad = 0;
  int s, d0, gaps, k;

  seg_led_shift_ctrl #(.CLK_DIV(CD), .SEG_BITS(64), .LED_BITS(16)) dut (
    .clk(clk), .rst(rst), .seg_wr(seg_wr), .seg_wdata(seg_wdata),
    .led_wr(led_wr), .led_wdata(led_wdata), .seg_busy(seg_busy), .led_busy(led_busy),
    .seg_done(seg_done), .led_done(led_done), .seg_clk(seg_clk), .seg_do(seg_do),
    .seg_pen(seg_pen), .seg_clr_n(seg_clr_n), .led_clk(led_clk), .led_do(led_do),
    .led_pen(led_pen), .led_clr_n(led_clr_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic bit cond(input int which);
    return which == 0 ? seg_done : which == 1 ? led_done : led_n >= which;
  endfunction

  task automatic wait_for(input string tag, input int which, input int budget);
    int n = 0;
    while (!cond(which) && n < budget) begin
      step();
      n++;
    end
    if (!cond(which)) chk(tag, 0, 1);
  endtask

  task automatic wr_led(input logic [15:0] d, input bit push);
    led_wr = 1;
    led_wdata = d;
    if (push) led_q.push_back(d);
    step();
    led_wr = 0;
  endtask

  task automatic wr_seg(input logic [63:0] d, input bit push);
    seg_wr = 1;
    seg_wdata = d;
    if (push) seg_q.push_back(d);
    step();
    seg_wr = 0;
  endtask

  // pin monitor: collects sampled bits per chain and scores each latched word
  always @(negedge clk) begin
    if (rst) begin
      led_n = 0;
      seg_n = 0;
    end else begin
      if (led_clk && !lc_q) begin
        led_sh = {led_sh[14:0], led_do};
        led_n++;
      end
      if (seg_clk && !sc_q) begin
        seg_sh = {seg_sh[62:0], seg_do};
        seg_n++;
      end
      if (!led_pen && lp_q) led_fall = cyc;
      if (!seg_pen && sp_q) seg_fall = cyc;
      if (!led_pen && (seg_clk || seg_do || !seg_pen)) iso_bad++;
      if (!seg_pen && (led_clk || led_do || !led_pen)) iso_bad++;
      if (led_done) begin
        led_done_cyc = cyc;
        led_dones++;
        if (led_q.size() == 0) chk("led_spurious_done", 1, 0);
        else chk("led_word", led_sh, led_q.pop_front());
        chk("led_bits", led_n, 16);
        led_n = 0;
      end
      if (seg_done) begin
        seg_done_cyc = cyc;
        seg_dones++;
        if (seg_q.size() == 0) chk("seg_spurious_done", 1, 0);
        else chk("seg_word", seg_sh, seg_q.pop_front());
        chk("seg_bits", seg_n, 64);
        seg_n = 0;
      end
    end
    lc_q = led_clk;
    sc_q = seg_clk;
    lp_q = led_pen;
    sp_q = seg_pen;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run still active, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) step();
    chk("rst_pins", {seg_clk, seg_do, seg_pen, seg_clr_n, led_clk, led_do, led_pen, led_clr_n,
                     seg_busy, led_busy, seg_done, led_done}, 12'b0010_0010_0000);
    rst = 0;
    step();
    chk("rst_release", {seg_clk, seg_do, seg_pen, seg_clr_n, led_clk, led_do, led_pen, led_clr_n,
                        seg_busy, led_busy, seg_done, led_done}, 12'b0011_0011_0000);

    repeat (6) step();
    wr_led(16'hA5C3, 1);
    s = cyc;
    wait_for("single_done_timeout", 1, 200);
    chk("single_pen_fall", led_fall - s, 2);
    chk("single_done_lat", cyc - s, LED_LAT);
    step();
    chk("single_busy_off", led_busy, 0);

    rst = 1;
    repeat (2) step();
    rst = 0;
    step();
    seg_wr = 1;
    led_wr = 1;
    seg_wdata = 64'h0123_4567_89AB_CDEF;
    led_wdata = 16'h3C5A;
    seg_q.push_back(seg_wdata);
    led_q.push_back(led_wdata);
    step();
    seg_wr = 0;
    led_wr = 0;
    s = cyc;
    wait_for("sim_seg_timeout", 0, 400);
    chk("sim_seg_lat", cyc - s, SEG_LAT);
    chk("sim_busy_at_seg_done", {seg_busy, led_busy}, 2'b11);
    step();
    chk("sim_busy_after_seg", {seg_busy, led_busy}, 2'b01);
    wait_for("sim_led_timeout", 1, 200);
    chk("sim_led_after_seg", led_done_cyc - seg_done_cyc, LED_LAT);
    step();
    chk("sim_busy_after_led", {seg_busy, led_busy}, 2'b00);

    wr_seg(64'hF0E1_D2C3_B4A5_9687, 1);
    repeat (3) step();
    wr_led(16'h0001, 0);
    repeat (2) step();
    wr_led(16'hFFFF, 1);
    d0 = led_dones;
    wait_for("ovw_seg_timeout", 0, 400);
    wait_for("ovw_led_timeout", 1, 200);
    repeat (100) step();
    chk("ovw_led_dones", led_dones - d0, 1);

    d0 = led_dones;
    wr_led(16'h1234, 1);
    wait_for("rw_mid_timeout", 3, 100);
    wr_led(16'h5678, 1);
    gaps = 0;
    k = 0;
    while (led_dones - d0 < 2 && k < 300) begin
      if (!led_busy) gaps++;
      step();
      k++;
    end
    chk("rw_led_dones", led_dones - d0, 2);
    chk("rw_busy_gaps", gaps, 0);

    repeat (3) step();
    d0 = led_dones;
    wr_led(16'hBEEF, 1);
    wait_for("rst_mid_5th_timeout", 5, 100);
    rst = 1;
    step();
    chk("rst_mid_pins", {led_clk, led_pen, led_clr_n, led_done}, 4'b0100);
    led_q.delete();
    step();
    rst = 0;
    repeat (100) step();
    chk("rst_mid_dones", led_dones - d0, 0);
    chk("rst_mid_idle", {seg_busy, led_busy, led_pen, led_clr_n}, 4'b0011);
    wr_led(16'h8001, 1);
    wait_for("post_rst_timeout", 1, 200);

    step();
    chk("pin_isolation", iso_bad, 0);
    chk("seg_q_empty", seg_q.size(), 0);
    chk("led_q_empty", led_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
